tpg_timing_ctrl: RTL and testbench
==================================

// Module: tpg_timing_ctrl
// PURPOSE
//  Run-time configuration and sequencing controller for the tpg video test pattern generator.
//  Holds a shadow set and an active set of the ten tpg timing values (tHS_*, tHACT_*, tH_END, tVS_*, tVACT_*, tV_END).
//  Validates shadow commits and copies them into the active set only at a frame boundary (vs_q rising edge).
//  Drives tpg's active-low reset so that tpg restarts cleanly on every timing change and on enable.
// PARAMETERS
//  H_BITS    12     width of the horizontal timing values
//  V_BITS    12     width of the vertical timing values
//  RST_CYC   4      cycles tpg_rst_n is held low in APPLY (>=1)
//  FRAME_TO  65535  PEND cycles without a vs_q rising edge before a forced apply
//  FC_BITS   16     width of frame_cnt
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        synchronous reset, active-high
//  cfg_valid    in   1        config write request
//  cfg_ready    out  1        config write accepted when cfg_valid&cfg_ready
//  cfg_addr     in   4        0..9 timing regs (order above), 10 CTRL, 11 ERR_CLR, 12 COMMIT
//  cfg_data     in   16       write data, LSBs used (H_BITS/V_BITS; CTRL bit0=en)
//  vs_q         in   1        vsync from tpg
//  tpg_rst_n    out  1        active-low reset to tpg
//  tHS_START..tV_END  out  H_BITS/V_BITS  active timing set, 10 ports, to tpg
//  busy         out  1        1 in PEND or APPLY
//  err          out  2        sticky: [0] invalid commit, [1] apply forced by timeout
//  frame_cnt    out  FC_BITS  vs_q rising edges counted in RUN, wraps
// BEHAVIOUR
//  Reset: state OFF, tpg_rst_n=0, all timing outputs 0, shadow 0, en=0, active_ok=0, busy=0, err=0,
//   frame_cnt=0, cfg_ready=1, vs_d=0.
//  Writes: accepted on cfg_valid&cfg_ready; addr 0..9 update shadow next cycle; 10 sets en; 11 clears err;
//   12 COMMIT; 13..15 are accepted and ignored. cfg_ready=0 only in APPLY.
//  COMMIT validity is checked on the current shadow:
//   HS_START<HS_END<=H_END, HACT_START<HACT_END<=H_END, VS_START<VS_END<=V_END,
//   VACT_START<VACT_END<=V_END, H_END>0, V_END>0.
//   Invalid: err[0]<=1; state, active set and pending status unchanged.
//  Edge detect: vs_d<=vs_q; vs_rise=vs_q&~vs_d. vs_d is forced to 0 while tpg_rst_n=0.
//  FSM:
//   OFF: tpg_rst_n=0. A valid COMMIT copies shadow->active next cycle and sets active_ok.
//    en&&active_ok -> RUN; tpg_rst_n=1 in the first RUN cycle.
//   RUN: frame_cnt++ on each vs_rise. Valid COMMIT -> PEND; timeout counter cleared.
//   PEND: active set unchanged; shadow writes still allowed; a further valid COMMIT is a no-op.
//    vs_rise -> APPLY. Timeout counter reaching FRAME_TO -> APPLY and err[1]<=1.
//   APPLY: in the first cycle, shadow->active and tpg_rst_n=0. Hold RST_CYC cycles total, then RUN
//    with tpg_rst_n=1. active_ok stays 1.
//  en=0 (CTRL write) in RUN/PEND/APPLY -> OFF next cycle: tpg_rst_n=0, busy=0.
//   A pending commit is dropped; an APPLY already started has already copied.
//  vs_rise coinciding with a COMMIT in RUN: counted; the commit waits for the next vs_rise.
//  rst in any state, including mid-APPLY, restores all reset values next cycle.
//  Active outputs change only on OFF-commit or APPLY entry, never mid-frame while tpg runs.
// TESTING
//  1 Write 10,20,40,50,60,11,21,25,35,40 to addr 0..9, COMMIT, CTRL=1
//    -> active equals those values 1 cycle after COMMIT; tpg_rst_n=1 1 cycle after CTRL.
//  2 Shadow HS_START=20, HS_END=10, COMMIT -> err=2'b01, active unchanged, state unchanged;
//    ERR_CLR -> err=0.
//  3 In RUN write tH_END=70, COMMIT -> busy=1, tH_END stays 60 until vs_q rises;
//    next cycle tH_END=70, tpg_rst_n=0 for 4 cycles, then 1, busy=0.
//  4 FRAME_TO=100, vs_q held 0, COMMIT in RUN -> APPLY 100 cycles later; err[1]=1.
//  5 CTRL=0 while PEND -> next cycle OFF, tpg_rst_n=0, busy=0, active unchanged;
//    re-enable -> RUN without applying the dropped shadow.
//  6 rst asserted 2 cycles into APPLY -> all outputs at reset values next cycle;
//    frame_cnt counts 3 after 3 vs_q pulses in RUN.

Source files
------------

// File: rtl/tpg_timing_ctrl.sv
// Shadow/active timing register set for the tpg pattern generator.
// Commits land on a frame boundary and restart tpg through its reset.
module tpg_timing_ctrl #(
  parameter int unsigned H_BITS   = 12,
  parameter int unsigned V_BITS   = 12,
  parameter int unsigned RST_CYC  = 4,
  parameter int unsigned FRAME_TO = 65535,
  parameter int unsigned FC_BITS  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [3:0]         cfg_addr,
  input  logic [15:0]        cfg_data,
  input  logic               vs_q,
  output logic               tpg_rst_n,
  output logic [H_BITS-1:0]  tHS_START,
  output logic [H_BITS-1:0]  tHS_END,
  output logic [H_BITS-1:0]  tHACT_START,
  output logic [H_BITS-1:0]  tHACT_END,
  output logic [H_BITS-1:0]  tH_END,
  output logic [V_BITS-1:0]  tVS_START,
  output logic [V_BITS-1:0]  tVS_END,
  output logic [V_BITS-1:0]  tVACT_START,
  output logic [V_BITS-1:0]  tVACT_END,
  output logic [V_BITS-1:0]  tV_END,
  output logic               busy,
  output logic [1:0]         err,
  output logic [FC_BITS-1:0] frame_cnt
);

  localparam int unsigned TO_W = $clog2(FRAME_TO + 1);
  localparam int unsigned RC_W = $clog2(RST_CYC + 1);

  typedef enum logic [1:0] {OFF, RUN, PEND, APPLY} stateT;

  stateT             state;
  logic [H_BITS-1:0] shH  [5];
  logic [V_BITS-1:0] shV  [5];
  logic [H_BITS-1:0] actH [5];
  logic [V_BITS-1:0] actV [5];
  logic              en;
  logic              activeOk;
  logic              vsD;
  logic [TO_W-1:0]   toCnt;
  logic [RC_W-1:0]   rstCnt;

  logic wr, isCommit, cmtValid, enNext, vsRise;
  logic unusedBits;

  assign wr         = cfg_valid & cfg_ready;
  assign isCommit   = wr && (cfg_addr == 4'd12);
  assign enNext     = (wr && cfg_addr == 4'd10) ? cfg_data[0] : en;
  assign vsRise     = vs_q & ~vsD;
  assign unusedBits = ^cfg_data;

  // Index map: H/V [0]=S_START [1]=S_END [2]=ACT_START [3]=ACT_END [4]=END
  assign cmtValid = (shH[0] < shH[1]) && (shH[1] <= shH[4]) &&
                    (shH[2] < shH[3]) && (shH[3] <= shH[4]) &&
                    (shV[0] < shV[1]) && (shV[1] <= shV[4]) &&
                    (shV[2] < shV[3]) && (shV[3] <= shV[4]) &&
                    (shH[4] != '0) && (shV[4] != '0);

  assign tHS_START   = actH[0];
  assign tHS_END     = actH[1];
  assign tHACT_START = actH[2];
  assign tHACT_END   = actH[3];
  assign tH_END      = actH[4];
  assign tVS_START   = actV[0];
  assign tVS_END     = actV[1];
  assign tVACT_START = actV[2];
  assign tVACT_END   = actV[3];
  assign tV_END      = actV[4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OFF;
      tpg_rst_n <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      err       <= 2'b00;
      frame_cnt <= '0;
      shH       <= '{default: '0};
      shV       <= '{default: '0};
      actH      <= '{default: '0};
      actV      <= '{default: '0};
      en        <= 1'b0;
      activeOk  <= 1'b0;
      vsD       <= 1'b0;
      toCnt     <= '0;
      rstCnt    <= '0;
    end else begin
      vsD <= tpg_rst_n ? vs_q : 1'b0;

      if (wr && cfg_addr <= 4'd4)
        shH[cfg_addr[2:0]] <= cfg_data[H_BITS-1:0];
      if (wr && cfg_addr >= 4'd5 && cfg_addr <= 4'd9)
        shV[3'(cfg_addr - 4'd5)] <= cfg_data[V_BITS-1:0];
      if (wr && cfg_addr == 4'd10)
        en <= cfg_data[0];
      if (wr && cfg_addr == 4'd11)
        err <= 2'b00;
      if (isCommit && !cmtValid)
        err[0] <= 1'b1;

      case (state)
        OFF: begin
          if (isCommit && cmtValid) begin
            actH     <= shH;
            actV     <= shV;
            activeOk <= 1'b1;
          end
          if (enNext && activeOk) begin
            state     <= RUN;
            tpg_rst_n <= 1'b1;
          end
        end
        RUN: begin
          if (vsRise)
            frame_cnt <= frame_cnt + FC_BITS'(1);
          if (!enNext) begin
            state     <= OFF;
            tpg_rst_n <= 1'b0;
          end else if (isCommit && cmtValid) begin
            state <= PEND;
            busy  <= 1'b1;
            toCnt <= '0;
          end
        end
        PEND: begin
          // Frame boundary or timeout both copy shadow and restart tpg
          if (!enNext) begin
            state     <= OFF;
            tpg_rst_n <= 1'b0;
            busy      <= 1'b0;
          end else if (vsRise || toCnt == TO_W'(FRAME_TO - 1)) begin
            state     <= APPLY;
            actH      <= shH;
            actV      <= shV;
            tpg_rst_n <= 1'b0;
            cfg_ready <= 1'b0;
            rstCnt    <= '0;
            if (!vsRise)
              err[1] <= 1'b1;
          end else begin
            toCnt <= toCnt + TO_W'(1);
          end
        end
        APPLY: begin
          if (!enNext) begin
            state     <= OFF;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (rstCnt == RC_W'(RST_CYC - 1)) begin
            state     <= RUN;
            tpg_rst_n <= 1'b1;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else begin
            rstCnt <= rstCnt + RC_W'(1);
          end
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_tpg_timing_ctrl.sv
// Directed bench for tpg_timing_ctrl; expectations are queued with a target
// cycle and a monitor compares them against the DUT at that cycle.
module tb_tpg_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_addr = 4'd0;
  logic [15:0] cfg_data = 16'd0;
  logic        vs_q = 1'b0;
  logic        tpg_rst_n;
  logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
  logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
  logic        busy;
  logic [1:0]  err;
  logic [15:0] frame_cnt;

  tpg_timing_ctrl #(
    .H_BITS(12), .V_BITS(12), .RST_CYC(4), .FRAME_TO(100), .FC_BITS(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .vs_q(vs_q), .tpg_rst_n(tpg_rst_n),
    .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
    .tHACT_END(tHACT_END), .tH_END(tH_END), .tVS_START(tVS_START),
    .tVS_END(tVS_END), .tVACT_START(tVACT_START), .tVACT_END(tVACT_END),
    .tV_END(tV_END), .busy(busy), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  localparam int RSTN = 0, BUSY = 1, ERR = 2, FCNT = 3, RDY = 4;
  localparam int HEND = 5, HSS = 6, VEND = 7, ASUM = 8;

  typedef struct {
    int    at;
    int    id;
    int    val;
    string nm;
  } expT;

  expT sbq[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sig(input int id);
    case (id)
      RSTN:    return int'(tpg_rst_n);
      BUSY:    return int'(busy);
      ERR:     return int'(err);
      FCNT:    return int'(frame_cnt);
      RDY:     return int'(cfg_ready);
      HEND:    return int'(tH_END);
      HSS:     return int'(tHS_START);
      VEND:    return int'(tV_END);
      default: return int'(tHS_START) + int'(tHS_END) + int'(tHACT_START) +
                      int'(tHACT_END) + int'(tH_END) + int'(tVS_START) +
                      int'(tVS_END) + int'(tVACT_START) + int'(tVACT_END) +
                      int'(tV_END);
    endcase
  endfunction

  // Queue an expectation visible dly clock edges from now
  task automatic expAt(input int dly, input int id, input int val, input string nm);
    expT e;
    e.at = cyc + dly; e.id = id; e.val = val; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Monitor: compare every expectation due at this cycle
  always begin
    @(posedge clk);
    #1;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].at <= cyc) begin
        checks++;
        if (sbq[i].at < cyc || sig(sbq[i].id) != sbq[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d due=%0d got=%0d exp=%0d",
                   sbq[i].nm, cyc, sbq[i].at, sig(sbq[i].id), sbq[i].val);
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vals [10];
    vals = '{16'd10, 16'd20, 16'd40, 16'd50, 16'd60, 16'd11, 16'd21, 16'd25, 16'd35, 16'd40};

    // Reset values
    repeat (2) @(negedge clk);
    expAt(1, RSTN, 0, "rst_rstn");
    expAt(1, RDY, 1, "rst_ready");
    expAt(1, ASUM, 0, "rst_active");
    expAt(1, ERR, 0, "rst_err");
    expAt(1, FCNT, 0, "rst_fcnt");
    expAt(1, BUSY, 0, "rst_busy");
    @(negedge clk);
    rst = 1'b0;

    // 1: load shadow, commit in OFF, enable
    for (int i = 0; i < 10; i++) begin
      if (i == 9) expAt(1, ASUM, 0, "t1_active_before_commit");
      wr(4'(i), vals[i]);
    end
    expAt(1, ASUM, 312, "t1_active_sum");
    expAt(1, HEND, 60, "t1_hend");
    expAt(1, HSS, 10, "t1_hs_start");
    expAt(1, VEND, 40, "t1_vend");
    expAt(1, RSTN, 0, "t1_rstn_off");
    wr(4'd12, 16'd0);
    expAt(1, RSTN, 1, "t1_rstn_run");
    expAt(1, BUSY, 0, "t1_busy_run");
    wr(4'd10, 16'd1);

    // 2: invalid commit, then clear
    wr(4'd0, 16'd20);
    wr(4'd1, 16'd10);
    expAt(1, ERR, 1, "t2_err_invalid");
    expAt(1, ASUM, 312, "t2_active_kept");
    expAt(1, BUSY, 0, "t2_state_kept");
    expAt(1, RSTN, 1, "t2_rstn_kept");
    wr(4'd12, 16'd0);
    expAt(1, ERR, 0, "t2_err_clr");
    wr(4'd11, 16'd0);
    wr(4'd0, 16'd10);
    wr(4'd1, 16'd20);

    // 3: commit in RUN waits for vs_q rise, then 4-cycle tpg reset
    wr(4'd4, 16'd70);
    expAt(1, BUSY, 1, "t3_busy_pend");
    expAt(1, HEND, 60, "t3_hend_held");
    wr(4'd12, 16'd0);
    repeat (3) @(negedge clk);
    expAt(0 + 0 + 1 - 1 + 1, HEND, 70, "t3_hend_applied");
    expAt(1, RSTN, 0, "t3_rstn_low_first");
    expAt(1, RDY, 0, "t3_ready_apply");
    expAt(1, BUSY, 1, "t3_busy_apply");
    expAt(4, RSTN, 0, "t3_rstn_low_last");
    expAt(5, RSTN, 1, "t3_rstn_high");
    expAt(5, BUSY, 0, "t3_busy_done");
    expAt(5, RDY, 1, "t3_ready_back");
    expAt(5, FCNT, 0, "t3_fcnt_pend_rise");
    vs_q = 1'b1;
    @(negedge clk);
    vs_q = 1'b0;
    repeat (6) @(negedge clk);

    // Frame counting in RUN
    for (int p = 0; p < 3; p++) begin
      expAt(1, FCNT, p + 1, "fcnt_pulse");
      vs_q = 1'b1;
      @(negedge clk);
      vs_q = 1'b0;
      @(negedge clk);
    end

    // 4: timeout forces apply after FRAME_TO cycles
    expAt(1, BUSY, 1, "t4_busy_pend");
    expAt(100, RSTN, 1, "t4_before_timeout");
    expAt(101, RSTN, 0, "t4_forced_apply");
    expAt(101, ERR, 2, "t4_err_timeout");
    expAt(105, RSTN, 1, "t4_run_again");
    wr(4'd12, 16'd0);
    repeat (106) @(negedge clk);
    expAt(1, ERR, 0, "t4_err_clr");
    wr(4'd11, 16'd0);

    // 5: disable while pending drops the commit
    wr(4'd4, 16'd80);
    expAt(1, BUSY, 1, "t5_busy_pend");
    wr(4'd12, 16'd0);
    repeat (2) @(negedge clk);
    expAt(1, RSTN, 0, "t5_rstn_off");
    expAt(1, BUSY, 0, "t5_busy_off");
    expAt(1, HEND, 70, "t5_hend_kept");
    wr(4'd10, 16'd0);
    expAt(1, RSTN, 1, "t5_rstn_reenable");
    expAt(1, HEND, 70, "t5_hend_not_applied");
    expAt(1, BUSY, 0, "t5_busy_reenable");
    wr(4'd10, 16'd1);

    // 6: reset in the middle of APPLY
    expAt(1, BUSY, 1, "t6_busy_pend");
    wr(4'd12, 16'd0);
    repeat (2) @(negedge clk);
    expAt(1, HEND, 80, "t6_hend_applied");
    expAt(2, RDY, 0, "t6_ready_apply");
    vs_q = 1'b1;
    @(negedge clk);
    vs_q = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expAt(1, ASUM, 0, "t6_active_reset");
    expAt(1, RSTN, 0, "t6_rstn_reset");
    expAt(1, BUSY, 0, "t6_busy_reset");
    expAt(1, FCNT, 0, "t6_fcnt_reset");
    expAt(1, RDY, 1, "t6_ready_reset");
    expAt(1, ERR, 0, "t6_err_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    if (sbq.size() != 0) begin
      foreach (sbq[i]) begin
        checks++;
        failures++;
        $display("FAIL %s got=unchecked exp=%0d", sbq[i].nm, sbq[i].val);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
